// File: rtl/vga_fb.sv
// VGA timing generator with framebuffer fetch: walks h/v counters, issues one BRAM read per
// visible pixel (with 2^SCALE_SHIFT pixel/line replication) and re-times syncs to the returned colour.
// Latency: address for pixel (x,y) is on bram_addrb while the counters sit at (x,y); the pixel's
// colour/de/syncs appear RD_LATENCY+1 clocks later. en=0 freezes everything (tie the BRAM read enable to en).
// Ports: clk/rst (async active-high), en, fb_base -> bram_addrb, bram_doutb -> red/green/blue,
//        hsync/vsync (active level SYNC_POL), de, frame_start (pulse with pixel (0,0)).
module vga_fb #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 0,
    parameter int RD_LATENCY  = 1,
    parameter bit SYNC_POL    = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] fb_base,
    output logic [15:0] bram_addrb,
    input  logic [15:0] bram_doutb,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_ROW   = H_VISIBLE >> SCALE_SHIFT;
    localparam int REP_MSK = (1 << SCALE_SHIFT) - 1;
    localparam int HS_BEG  = H_VISIBLE + H_FP;
    localparam int HS_END  = H_VISIBLE + H_FP + H_SYNC;
    localparam int VS_BEG  = V_VISIBLE + V_FP;
    localparam int VS_END  = V_VISIBLE + V_FP + V_SYNC;

    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;
    logic          h_last, v_last, frame_wrap, vis_nxt;

    // row_off is relative to the frame base so the base can be swapped at frame wrap
    logic [15:0] row_off, row_nxt;
    logic [15:0] col_off, col_nxt;
    logic [15:0] fb_base_q, base_nxt, addr_nxt;

    logic de_raw, hs_raw, vs_raw, fs_raw;
    logic [RD_LATENCY:0] de_pipe, hs_pipe, vs_pipe, fs_pipe;
    logic [11:0] rgb_q;

    // Only the colour bits of the read word are used.
    logic unused_doutb;
    assign unused_doutb = ^bram_doutb[15:12];

    // ---------------- next counter position ----------------
    always_comb begin
        h_last     = (h_cnt == HW'(H_TOTAL - 1));
        v_last     = (v_cnt == VW'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;
        h_nxt      = h_last ? '0 : h_cnt + HW'(1);
        v_nxt      = v_cnt;
        if (h_last) begin
            v_nxt = v_last ? '0 : v_cnt + VW'(1);
        end
        vis_nxt = (h_nxt < HW'(H_VISIBLE)) && (v_nxt < VW'(V_VISIBLE));
    end

    // ---------------- incremental address for the next position ----------------
    // The read address is registered, so it is computed one position ahead: when the
    // counters land on (x,y) the address register already holds (x,y)'s word.
    always_comb begin
        col_nxt = col_off;
        if (h_nxt == '0) begin
            col_nxt = '0;
        end else if ((h_nxt & HW'(REP_MSK)) == '0) begin
            col_nxt = col_off + 16'd1;
        end

        row_nxt = row_off;
        if (frame_wrap) begin
            row_nxt = '0;
        end else if (h_last && (v_cnt < VW'(V_VISIBLE)) &&
                     ((v_nxt & VW'(REP_MSK)) == '0)) begin
            row_nxt = row_off + 16'(H_ROW);
        end

        // At frame wrap the new base is being captured this very edge; use it directly.
        base_nxt = frame_wrap ? fb_base : fb_base_q;
        addr_nxt = base_nxt + row_nxt + col_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            row_off    <= '0;
            col_off    <= '0;
            fb_base_q  <= '0;
            bram_addrb <= '0;
        end else if (en) begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            row_off <= row_nxt;
            col_off <= col_nxt;
            if (frame_wrap) begin
                fb_base_q <= fb_base;
            end
            // Blanking keeps the last fetched address on the bus.
            if (vis_nxt) begin
                bram_addrb <= addr_nxt;
            end
        end
    end

    // ---------------- timing strobes for the current position ----------------
    always_comb begin
        de_raw = (h_cnt < HW'(H_VISIBLE)) && (v_cnt < VW'(V_VISIBLE));
        hs_raw = (h_cnt >= HW'(HS_BEG)) && (h_cnt < HW'(HS_END));
        vs_raw = (v_cnt >= VW'(VS_BEG)) && (v_cnt < VW'(VS_END));
        fs_raw = (h_cnt == '0) && (v_cnt == '0);
    end

    // Strobes travel as active-high flags so a cleared pipeline means "sync inactive";
    // the polarity is applied only at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_pipe <= '0;
            hs_pipe <= '0;
            vs_pipe <= '0;
            fs_pipe <= '0;
            rgb_q   <= '0;
        end else if (en) begin
            de_pipe <= {de_pipe[RD_LATENCY-1:0], de_raw};
            hs_pipe <= {hs_pipe[RD_LATENCY-1:0], hs_raw};
            vs_pipe <= {vs_pipe[RD_LATENCY-1:0], vs_raw};
            fs_pipe <= {fs_pipe[RD_LATENCY-1:0], fs_raw};
            // Stage RD_LATENCY-1 lines up with the read data now on bram_doutb.
            rgb_q   <= de_pipe[RD_LATENCY-1] ? bram_doutb[11:0] : 12'h000;
        end
    end

    assign red         = rgb_q[11:8];
    assign green       = rgb_q[7:4];
    assign blue        = rgb_q[3:0];
    assign de          = de_pipe[RD_LATENCY];
    assign frame_start = fs_pipe[RD_LATENCY];
    assign hsync       = hs_pipe[RD_LATENCY] ? SYNC_POL : ~SYNC_POL;
    assign vsync       = vs_pipe[RD_LATENCY] ? SYNC_POL : ~SYNC_POL;

endmodule
